// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data memory responder and its storage array.
package mem_resp_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // Only naturally aligned doublewords inside the array are legal.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (addr[2:0] != 3'b000) || ((addr >> 3) >= ADDR_W'(depth));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Doubleword storage: synchronous write, combinational read, never cleared by reset.
module dmem_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IdxW-1:0]   waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IdxW-1:0]   raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: one outstanding request, fixed wait states,
// response held until the pipeline accepts it.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WAIT_W-1:0] WaitLoad = WAIT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              busy_q, busy_d;
  logic              req_ready_q, req_ready_d;

  logic              accept;
  logic              commit;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_err;
  logic [IdxW-1:0]   cur_idx;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata;

  assign accept = req_valid && req_ready_q;

  // A zero-wait acceptance commits in the same edge, straight from the request inputs.
  assign cur_we    = (state_q == StIdle) ? req_we    : we_q;
  assign cur_addr  = (state_q == StIdle) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
  assign cur_err   = addr_err(cur_addr, DEPTH);
  assign cur_idx   = cur_addr[IdxW+2:3];

  // Reset on the commit edge still suppresses the write.
  assign arr_we = commit && cur_we && !cur_err && !rst;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_dmem_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .waddr_i (cur_idx),
    .wdata_i (cur_wdata),
    .raddr_i (cur_idx),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    busy_d      = busy_q;
    req_ready_d = req_ready_q;
    commit      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = WaitLoad;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // Leave on the edge where the counter reaches zero.
        if (cnt_q <= WAIT_W'(1)) begin
          cnt_d   = '0;
          commit  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          busy_d      = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (commit) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = cur_err;
      rsp_rdata_d = (cur_we || cur_err) ? '0 : arr_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: two instances (2 and 0 wait states)
// checked against a transaction-level memory model.
module tb_data_mem_responder;

  localparam int unsigned DepthA = 256;
  localparam int unsigned WaitA  = 2;
  localparam int unsigned DepthB = 16;
  localparam int unsigned WaitB  = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req_valid = '0;
  logic [1:0]  req_we    = '0;
  logic [1:0]  rsp_ready = '0;
  logic [63:0] req_addr  [2];
  logic [63:0] req_wdata [2];

  logic        req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b;
  logic        rsp_err_a, rsp_err_b, busy_a, busy_b;
  logic [63:0] rsp_rdata_a, rsp_rdata_b;

  logic [1:0]  req_ready_w, rsp_valid_w, rsp_err_w, busy_w;
  logic [63:0] rsp_rdata_w [2];

  assign req_ready_w    = {req_ready_b, req_ready_a};
  assign rsp_valid_w    = {rsp_valid_b, rsp_valid_a};
  assign rsp_err_w      = {rsp_err_b, rsp_err_a};
  assign busy_w         = {busy_b, busy_a};
  assign rsp_rdata_w[0] = rsp_rdata_a;
  assign rsp_rdata_w[1] = rsp_rdata_b;

  data_mem_responder #(
    .DEPTH       (DepthA),
    .WAIT_CYCLES (WaitA)
  ) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[0]),
    .req_ready (req_ready_a),
    .req_we    (req_we[0]),
    .req_addr  (req_addr[0]),
    .req_wdata (req_wdata[0]),
    .rsp_valid (rsp_valid_a),
    .rsp_ready (rsp_ready[0]),
    .rsp_rdata (rsp_rdata_a),
    .rsp_err   (rsp_err_a),
    .busy      (busy_a)
  );

  data_mem_responder #(
    .DEPTH       (DepthB),
    .WAIT_CYCLES (WaitB)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[1]),
    .req_ready (req_ready_b),
    .req_we    (req_we[1]),
    .req_addr  (req_addr[1]),
    .req_wdata (req_wdata[1]),
    .rsp_valid (rsp_valid_b),
    .rsp_ready (rsp_ready[1]),
    .rsp_rdata (rsp_rdata_b),
    .rsp_err   (rsp_err_b),
    .busy      (busy_b)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] model [2][256];

  function automatic int unsigned depth_of(input int inst);
    return (inst == 0) ? DepthA : DepthB;
  endfunction

  function automatic int unsigned wait_of(input int inst);
    return (inst == 0) ? WaitA : WaitB;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One full transaction, optionally stalling the response for `hold` cycles while
  // presenting a competing request that must be ignored.
  task automatic do_txn(input int inst, input bit we, input logic [63:0] addr,
                        input logic [63:0] wdata, input int hold);
    bit          err;
    logic [63:0] exp_rd;
    int          lat;
    err    = (addr % 8 != 0) || (addr / 8 >= 64'(depth_of(inst)));
    exp_rd = (we || err) ? 64'h0 : model[inst][int'(addr / 8)];

    @(negedge clk);
    check("idle_req_ready", 64'(req_ready_w[inst]), 64'h1);
    req_valid[inst] = 1'b1;
    req_we[inst]    = we;
    req_addr[inst]  = addr;
    req_wdata[inst] = wdata;
    @(negedge clk);
    req_valid[inst] = 1'b0;
    lat = 1;
    if (!rsp_valid_w[inst]) check("wait_busy", 64'(busy_w[inst]), 64'h1);
    while (!rsp_valid_w[inst] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(wait_of(inst) + 1));
    check("rsp_err", 64'(rsp_err_w[inst]), 64'(err));
    check("rsp_rdata", rsp_rdata_w[inst], exp_rd);

    for (int i = 0; i < hold; i++) begin
      req_valid[inst] = 1'b1;
      req_we[inst]    = 1'b1;
      req_addr[inst]  = 64'h18;
      req_wdata[inst] = {$urandom, $urandom};
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid_w[inst]), 64'h1);
      check("hold_rdata", rsp_rdata_w[inst], exp_rd);
      check("hold_err", 64'(rsp_err_w[inst]), 64'(err));
      check("hold_busy", 64'(busy_w[inst]), 64'h1);
      check("hold_req_ready", 64'(req_ready_w[inst]), 64'h0);
    end

    req_valid[inst] = 1'b0;
    rsp_ready[inst] = 1'b1;
    @(negedge clk);
    rsp_ready[inst] = 1'b0;
    check("done_rsp_valid", 64'(rsp_valid_w[inst]), 64'h0);
    check("done_req_ready", 64'(req_ready_w[inst]), 64'h1);
    check("done_busy", 64'(busy_w[inst]), 64'h0);
    if (we && !err) model[inst][int'(addr / 8)] = wdata;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int          inst;
    bit          we;
    int          idx;
    int          r;
    logic [63:0] addr;

    for (int i = 0; i < 2; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_req_ready", 64'(req_ready_w[i]), 64'h1);
      check("rst_busy", 64'(busy_w[i]), 64'h0);
      check("rst_rsp_valid", 64'(rsp_valid_w[i]), 64'h0);
      check("rst_rsp_err", 64'(rsp_err_w[i]), 64'h0);
      check("rst_rsp_rdata", rsp_rdata_w[i], 64'h0);
    end
    rst = 1'b0;

    // Known contents for indices 0..15 of both arrays.
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 16; j++) begin
        do_txn(i, 1'b1, 64'(j) * 8, {$urandom, $urandom}, 0);
      end
    end

    do_txn(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 0);
    do_txn(0, 1'b0, 64'h10, 64'h0, 0);
    do_txn(0, 1'b0, 64'h13, 64'h0, 0);
    do_txn(0, 1'b0, 64'(DepthA) * 8, 64'h0, 0);
    do_txn(0, 1'b1, 64'h13, 64'h1111_2222_3333_4444, 0);
    do_txn(0, 1'b0, 64'h10, 64'h0, 0);
    do_txn(0, 1'b0, 64'h10, 64'h0, 5);

    do_txn(1, 1'b1, 64'h28, 64'h0123_4567_89AB_CDEF, 0);
    do_txn(1, 1'b0, 64'h28, 64'h0, 0);
    do_txn(1, 1'b0, 64'(DepthB) * 8, 64'h0, 3);

    do_txn(0, 1'b1, 64'h20, 64'h1, 0);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 64'h20;
    req_wdata[0] = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("abort_busy_before", 64'(busy_w[0]), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_req_ready", 64'(req_ready_w[0]), 64'h1);
    check("abort_busy", 64'(busy_w[0]), 64'h0);
    for (int i = 0; i < 4; i++) begin
      check("abort_rsp_valid", 64'(rsp_valid_w[0]), 64'h0);
      @(negedge clk);
    end
    do_txn(0, 1'b0, 64'h20, 64'h0, 0);

    repeat (90) begin
      inst = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      idx  = int'($urandom_range(0, 15));
      addr = 64'(idx) * 8;
      r    = int'($urandom_range(0, 9));
      if (r == 0) addr = addr | 64'($urandom_range(1, 7));
      else if (r == 1) addr = 64'(depth_of(inst)) * 8 + addr;
      else if (r == 2) addr = {$urandom, $urandom} | 64'h1000_0000_0000_0000;
      do_txn(inst, we, addr, {$urandom, $urandom}, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 64-bit doublewords stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, access-latency wait states (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  MEM-stage request present.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store doubleword, 0 = load.
REQ-008 SHALL have port req_addr  input  64  byte address.
REQ-009 SHALL have port req_wdata  input  64  store data.
REQ-010 SHALL have port rsp_valid  output  1  response present.
REQ-011 SHALL have port rsp_ready  input  1  pipeline accepts response.
REQ-012 SHALL have port rsp_rdata  output  64  load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  misaligned or out-of-range access.
REQ-014 SHALL have port busy  output  1  stall request to hazard logic; high in WAIT and RESP.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted when req_valid & req_ready on a posedge.
REQ-017 On acceptance SHALL register we, addr, wdata and load the wait counter with WAIT_CYCLES.
REQ-018 IDLE -> WAIT on acceptance when WAIT_CYCLES > 0; IDLE -> RESP on acceptance when WAIT_CYCLES = 0.
REQ-019 In WAIT SHALL decrement the counter each cycle and move to RESP in the cycle it reaches 0; accept-to-rsp_valid latency = WAIT_CYCLES + 1 cycles.
REQ-020 Index = addr[63:3]; error when addr[2:0] != 0 or index >= DEPTH.
REQ-021 Store without error SHALL write the array exactly once, on the WAIT->RESP (or IDLE->RESP) transition edge.
REQ-022 Load without error SHALL present array[index] on rsp_rdata, stable while rsp_valid is high.
REQ-023 Error access SHALL not modify the array; rsp_err = 1, rsp_rdata = 0.
REQ-024 rsp_valid high only in RESP; rsp_valid, rsp_rdata and rsp_err SHALL hold until rsp_ready.
REQ-025 RESP -> IDLE on rsp_valid & rsp_ready; the next request is accepted no earlier than the following cycle (no same-cycle back-to-back).
REQ-026 req_valid in WAIT/RESP SHALL be ignored (req_ready = 0); no request queuing.
REQ-027 A load immediately after a store to the same index SHALL return the stored data.

Reset
REQ-028 On rst SHALL force state IDLE, counter 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, busy 0, req_ready 1 on the next cycle.
REQ-029 Reset mid-operation SHALL abort the transaction without a response; a store not yet committed (REQ-021) SHALL not be written.
REQ-030 Array contents SHALL NOT be cleared by rst.

Structure
REQ-031 Shared package mem_resp_pkg SHALL hold the FSM state enum, DATA_W = 64, ADDR_W = 64, and the WAIT counter width.
REQ-032 Storage SHALL be a sub-module dmem_array (synchronous write, combinational read, DEPTH parameter).

Verification
REQ-033 Reset, then store addr 0x10 data 0xDEADBEEF_CAFEF00D, WAIT_CYCLES = 2 -> rsp_valid 3 cycles after accept, rsp_err 0, rsp_rdata 0; load 0x10 -> rdata 0xDEADBEEF_CAFEF00D.
REQ-034 Load addr 0x13 (misaligned) and addr 8*DEPTH -> rsp_err 1, rdata 0; a following load of 0x10 still returns the prior value.
REQ-035 Hold rsp_ready 0 for 5 cycles during RESP -> rsp_valid/rdata/err stable, busy 1, req_ready 0; drive req_valid meanwhile -> not accepted.
REQ-036 WAIT_CYCLES = 0 -> rsp_valid exactly 1 cycle after accept; back-to-back store/load of index 5 returns the store data.
REQ-037 Assert rst during WAIT of a store to 0x20 (old value 0x1) -> no rsp_valid, IDLE next cycle, later load of 0x20 returns 0x1.
